ram32x16_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer in front of one `Wrapped32x16RAM` instance. It accepts read/write requests from two independent requesters over valid/ready handshakes and grants at most one request per cycle. It drives the RAM's single `we`/`addr`/`din` port and returns a registered response to the granted requester. With scrub compiled in, it first clears the whole RAM after reset before it serves any traffic.

---
 rtl/ram32x16_arbiter.sv | 152 +++++++++++++++
 tb/tb_ram32x16_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram32x16_arbiter.sv
// ============================================================================
// ram32x16_arbiter
// Round-robin two-requester arbiter/sequencer driving one 32x16 RAM port.
// Optional post-reset RAM scrub is compiled in with `define RAM_ARB_SCRUB_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ram32x16_arbiter #(
    parameter int                 ADDR_W      = 5,
    parameter int                 DATA_W      = 16,
    parameter logic [DATA_W-1:0]  SCRUB_VALUE = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid_0,
    output logic              req_ready_0,
    input  logic              req_we_0,
    input  logic [ADDR_W-1:0] req_addr_0,
    input  logic [DATA_W-1:0] req_wdata_0,
    input  logic              req_valid_1,
    output logic              req_ready_1,
    input  logic              req_we_1,
    input  logic [ADDR_W-1:0] req_addr_1,
    input  logic [DATA_W-1:0] req_wdata_1,
    output logic              rsp_valid_0,
    output logic [DATA_W-1:0] rsp_data_0,
    output logic              rsp_valid_1,
    output logic [DATA_W-1:0] rsp_data_1,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy
);

    typedef enum logic [0:0] {
        ST_SCRUB = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

`ifdef RAM_ARB_SCRUB_EN
    localparam state_t RESET_STATE = ST_SCRUB;
`else
    localparam state_t RESET_STATE = ST_SERVE;
`endif

    state_t              state_q, state_d;
    logic                last_q, last_d;       // index of the most recent grant
    logic                rsp_valid_0_q, rsp_valid_1_q;
    logic [DATA_W-1:0]   rsp_data_0_q, rsp_data_1_q;
    logic [ADDR_W-1:0]   w_scrub_addr;
    logic                w_gnt0, w_gnt1;

`ifdef RAM_ARB_SCRUB_EN
    logic [ADDR_W-1:0]   scrub_cnt_q, scrub_cnt_d;
    assign w_scrub_addr = scrub_cnt_q;
`else
    assign w_scrub_addr = '0;
`endif

    // Port 0 wins a tie only when port 1 was the most recent winner.
    assign w_gnt0 = req_valid_0 && (!req_valid_1 || last_q);
    assign w_gnt1 = req_valid_1 && !w_gnt0;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        req_ready_0 = 1'b0;
        req_ready_1 = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = '0;
        ram_din     = '0;
        busy        = 1'b0;
`ifdef RAM_ARB_SCRUB_EN
        scrub_cnt_d = scrub_cnt_q;
`endif
        // Outputs are held quiet while reset_n is low, independent of state.
        if (reset_n) begin
            case (state_q)
                ST_SCRUB: begin
                    ram_we   = 1'b1;
                    ram_addr = w_scrub_addr;
                    ram_din  = SCRUB_VALUE;
`ifdef RAM_ARB_SCRUB_EN
                    busy        = 1'b1;
                    scrub_cnt_d = scrub_cnt_q + 1'b1;
                    if (&scrub_cnt_q) begin
                        state_d = ST_SERVE;
                    end
`else
                    state_d = ST_SERVE;
`endif
                end
                ST_SERVE: begin
                    req_ready_0 = w_gnt0;
                    req_ready_1 = w_gnt1;
                    if (w_gnt0) begin
                        ram_we   = req_we_0;
                        ram_addr = req_addr_0;
                        ram_din  = req_wdata_0;
                    end else if (w_gnt1) begin
                        ram_we   = req_we_1;
                        ram_addr = req_addr_1;
                        ram_din  = req_wdata_1;
                    end
                    if (w_gnt0 || w_gnt1) begin
                        last_d = w_gnt1;
                    end
                end
                default: state_d = RESET_STATE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= RESET_STATE;
            last_q        <= 1'b1;
            rsp_valid_0_q <= 1'b0;
            rsp_valid_1_q <= 1'b0;
            rsp_data_0_q  <= '0;
            rsp_data_1_q  <= '0;
`ifdef RAM_ARB_SCRUB_EN
            scrub_cnt_q   <= '0;
`endif
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            rsp_valid_0_q <= req_ready_0;
            rsp_valid_1_q <= req_ready_1;
            // ram_dout reflects the granted address, so a read returns pre-edge contents.
            if (req_ready_0) begin
                rsp_data_0_q <= req_we_0 ? req_wdata_0 : ram_dout;
            end
            if (req_ready_1) begin
                rsp_data_1_q <= req_we_1 ? req_wdata_1 : ram_dout;
            end
`ifdef RAM_ARB_SCRUB_EN
            scrub_cnt_q   <= scrub_cnt_d;
`endif
        end
    end

    assign rsp_valid_0 = rsp_valid_0_q;
    assign rsp_valid_1 = rsp_valid_1_q;
    assign rsp_data_0  = rsp_data_0_q;
    assign rsp_data_1  = rsp_data_1_q;

endmodule

`default_nettype wire

// File: tb/tb_ram32x16_arbiter.sv
// ============================================================================
// tb_ram32x16_arbiter
// Scoreboard bench for ram32x16_arbiter with a behavioural 32x16 RAM attached.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ram32x16_arbiter;

    localparam int          ADDR_W      = 5;
    localparam int          DATA_W      = 16;
    localparam logic [15:0] SCRUB_VALUE = 16'h0000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid_0 = 1'b0, req_we_0 = 1'b0;
    logic        req_valid_1 = 1'b0, req_we_1 = 1'b0;
    logic [4:0]  req_addr_0 = '0, req_addr_1 = '0;
    logic [15:0] req_wdata_0 = '0, req_wdata_1 = '0;
    logic        req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1;
    logic [15:0] rsp_data_0, rsp_data_1;
    logic        ram_we, busy;
    logic [4:0]  ram_addr;
    logic [15:0] ram_din, ram_dout;

    always #5 clock = ~clock;

    ram32x16_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .SCRUB_VALUE (SCRUB_VALUE)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid_0 (req_valid_0),
        .req_ready_0 (req_ready_0),
        .req_we_0    (req_we_0),
        .req_addr_0  (req_addr_0),
        .req_wdata_0 (req_wdata_0),
        .req_valid_1 (req_valid_1),
        .req_ready_1 (req_ready_1),
        .req_we_1    (req_we_1),
        .req_addr_1  (req_addr_1),
        .req_wdata_1 (req_wdata_1),
        .rsp_valid_0 (rsp_valid_0),
        .rsp_data_0  (rsp_data_0),
        .rsp_valid_1 (rsp_valid_1),
        .rsp_data_1  (rsp_data_1),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_din     (ram_din),
        .ram_dout    (ram_dout),
        .busy        (busy)
    );

    // Behavioural RAM: synchronous write, asynchronous read, nonzero INIT pattern.
    logic [15:0] ram_mem [32];
    initial begin
        for (int i = 0; i < 32; i++) ram_mem[i] <= 16'h1ec2 ^ 16'(i * 16'h1111);
    end
    always @(posedge clock) if (ram_we) ram_mem[ram_addr] <= ram_din;
    assign ram_dout = ram_mem[ram_addr];

    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t        q0[$], q1[$];
    exp_t        e0, e1, en;
    logic [15:0] model_mem [32];
    logic        model_last;
    logic        exp_g0, exp_g1;
    int          cyc = 0;
    int          nvec = 0;
    int          nerr = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Drives one request cycle and pushes the model's expected responses.
    task automatic drive(input logic v0, input logic w0, input logic [4:0] a0, input logic [15:0] d0,
                         input logic v1, input logic w1, input logic [4:0] a1, input logic [15:0] d1);
        @(negedge clock);
        req_valid_0 = v0; req_we_0 = w0; req_addr_0 = a0; req_wdata_0 = d0;
        req_valid_1 = v1; req_we_1 = w1; req_addr_1 = a1; req_wdata_1 = d1;
        #1;
        exp_g0 = v0 && (!v1 || model_last);
        exp_g1 = v1 && !exp_g0;
        if (exp_g0) begin
            en.data = w0 ? d0 : model_mem[a0];
            en.due  = cyc + 1;
            q0.push_back(en);
            if (w0) model_mem[a0] = d0;
            model_last = 1'b0;
        end else if (exp_g1) begin
            en.data = w1 ? d1 : model_mem[a1];
            en.due  = cyc + 1;
            q1.push_back(en);
            if (w1) model_mem[a1] = d1;
            model_last = 1'b1;
        end
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset_n = 1'b0;
        req_valid_0 = 1'b0; req_valid_1 = 1'b0;
        repeat (2) @(negedge clock);
        q0.delete(); q1.delete();
        model_last = 1'b1;
`ifdef RAM_ARB_SCRUB_EN
        for (int i = 0; i < 32; i++) model_mem[i] = SCRUB_VALUE;
`endif
        reset_n = 1'b1;
`ifdef RAM_ARB_SCRUB_EN
        repeat (32) @(negedge clock);
`endif
    endtask

    // Response monitor: pops the scoreboard whenever a response pulse appears.
    always @(negedge clock) begin
        if (reset_n) begin
            if (rsp_valid_0 === 1'b1) begin
                nvec++;
                if (q0.size() == 0) begin
                    nerr++;
                    $display("FAIL rsp0_unexpected: got data %h, expected no response (cycle %0d)", rsp_data_0, cyc);
                end else begin
                    e0 = q0.pop_front();
                    if (rsp_data_0 !== e0.data || cyc != e0.due) begin
                        nerr++;
                        $display("FAIL rsp0_data: got %h at cycle %0d, expected %h at cycle %0d", rsp_data_0, cyc, e0.data, e0.due);
                    end
                end
            end else if (q0.size() != 0 && q0[0].due <= cyc) begin
                nvec++; nerr++;
                $display("FAIL rsp0_missing: got valid %b, expected response %h at cycle %0d", rsp_valid_0, q0[0].data, q0[0].due);
                void'(q0.pop_front());
            end
            if (rsp_valid_1 === 1'b1) begin
                nvec++;
                if (q1.size() == 0) begin
                    nerr++;
                    $display("FAIL rsp1_unexpected: got data %h, expected no response (cycle %0d)", rsp_data_1, cyc);
                end else begin
                    e1 = q1.pop_front();
                    if (rsp_data_1 !== e1.data || cyc != e1.due) begin
                        nerr++;
                        $display("FAIL rsp1_data: got %h at cycle %0d, expected %h at cycle %0d", rsp_data_1, cyc, e1.data, e1.due);
                    end
                end
            end else if (q1.size() != 0 && q1[0].due <= cyc) begin
                nvec++; nerr++;
                $display("FAIL rsp1_missing: got valid %b, expected response %h at cycle %0d", rsp_valid_1, q1[0].data, q1[0].due);
                void'(q1.pop_front());
            end
        end
    end

    task automatic test_reset();
        reset_n = 1'b0;
        req_valid_0 = 1'b1; req_we_0 = 1'b1; req_addr_0 = 5'd3; req_wdata_0 = 16'hFFFF;
        req_valid_1 = 1'b1; req_we_1 = 1'b1; req_addr_1 = 5'd4; req_wdata_1 = 16'hEEEE;
        repeat (2) @(negedge clock);
        #1;
        nvec += 10;
        if (req_ready_0 !== 1'b0) begin nerr++; $display("FAIL reset_ready0: got %b, expected 0", req_ready_0); end
        if (req_ready_1 !== 1'b0) begin nerr++; $display("FAIL reset_ready1: got %b, expected 0", req_ready_1); end
        if (rsp_valid_0 !== 1'b0) begin nerr++; $display("FAIL reset_rsp_valid0: got %b, expected 0", rsp_valid_0); end
        if (rsp_valid_1 !== 1'b0) begin nerr++; $display("FAIL reset_rsp_valid1: got %b, expected 0", rsp_valid_1); end
        if (rsp_data_0 !== 16'h0) begin nerr++; $display("FAIL reset_rsp_data0: got %h, expected 0000", rsp_data_0); end
        if (rsp_data_1 !== 16'h0) begin nerr++; $display("FAIL reset_rsp_data1: got %h, expected 0000", rsp_data_1); end
        if (ram_we !== 1'b0) begin nerr++; $display("FAIL reset_ram_we: got %b, expected 0", ram_we); end
        if (ram_addr !== 5'd0) begin nerr++; $display("FAIL reset_ram_addr: got %h, expected 00", ram_addr); end
        if (ram_din !== 16'h0) begin nerr++; $display("FAIL reset_ram_din: got %h, expected 0000", ram_din); end
        if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        apply_reset();
    endtask

`ifndef RAM_ARB_SCRUB_EN
    task automatic test_init_read();
        drive(1'b1, 1'b0, 5'd0, 16'h0, 1'b0, 1'b0, 5'd0, 16'h0);
        nvec++;
        if (req_ready_0 !== 1'b1) begin nerr++; $display("FAIL init_ready0: got %b, expected 1", req_ready_0); end
        drive(1'b0, 1'b0, 5'd0, 16'h0, 1'b0, 1'b0, 5'd0, 16'h0);
        nvec++;
        if (rsp_valid_0 !== 1'b1 || rsp_data_0 !== 16'h1ec2) begin
            nerr++; $display("FAIL init_read: got valid %b data %h, expected 1 1ec2", rsp_valid_0, rsp_data_0);
        end
    endtask
`endif

`ifdef RAM_ARB_SCRUB_EN
    task automatic test_scrub();
        @(negedge clock);
        reset_n = 1'b0;
        req_valid_0 = 1'b1; req_we_0 = 1'b0; req_addr_0 = 5'd7; req_valid_1 = 1'b0;
        repeat (2) @(negedge clock);
        q0.delete(); q1.delete();
        model_last = 1'b1;
        for (int i = 0; i < 32; i++) model_mem[i] = SCRUB_VALUE;
        reset_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            #1;
            nvec++;
            if (busy !== 1'b1 || req_ready_0 !== 1'b0 || ram_we !== 1'b1 || ram_addr !== 5'(i) || ram_din !== SCRUB_VALUE) begin
                nerr++;
                $display("FAIL scrub_cycle%0d: got busy %b ready %b we %b addr %0d din %h, expected 1 0 1 %0d %h",
                         i, busy, req_ready_0, ram_we, ram_addr, ram_din, i, SCRUB_VALUE);
            end
            @(negedge clock);
        end
        #1;
        en.data = model_mem[7]; en.due = cyc + 1; q0.push_back(en); model_last = 1'b0;
        nvec++;
        if (busy !== 1'b0 || req_ready_0 !== 1'b1) begin
            nerr++; $display("FAIL scrub_first_serve: got busy %b ready %b, expected 0 1", busy, req_ready_0);
        end
        @(negedge clock);
        req_valid_0 = 1'b0;
        nvec++;
        if (rsp_valid_0 !== 1'b1 || rsp_data_0 !== 16'h0000) begin
            nerr++; $display("FAIL scrub_read7: got valid %b data %h, expected 1 0000", rsp_valid_0, rsp_data_0);
        end
        // Interrupt a second scrub at address 10 and expect a full restart.
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) @(negedge clock);
        #1;
        nvec++;
        if (ram_addr !== 5'd10 || busy !== 1'b1) begin
            nerr++; $display("FAIL scrub_mid_addr: got addr %0d busy %b, expected 10 1", ram_addr, busy);
        end
        reset_n = 1'b0;
        @(negedge clock);
        #1;
        nvec++;
        if (ram_addr !== 5'd0 || busy !== 1'b0 || ram_we !== 1'b0) begin
            nerr++; $display("FAIL scrub_mid_reset: got addr %0d busy %b we %b, expected 0 0 0", ram_addr, busy, ram_we);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            #1;
            nvec++;
            if (busy !== 1'b1 || ram_addr !== 5'(i)) begin
                nerr++; $display("FAIL scrub_restart%0d: got busy %b addr %0d, expected 1 %0d", i, busy, ram_addr, i);
            end
            @(negedge clock);
        end
        #1;
        nvec++;
        if (busy !== 1'b0) begin nerr++; $display("FAIL scrub_restart_done: got busy %b, expected 0", busy); end
    endtask
`endif

    task automatic test_write_read();
        drive(1'b1, 1'b1, 5'd5, 16'hB70D, 1'b0, 1'b0, 5'd0, 16'h0);
        nvec++;
        if (req_ready_0 !== 1'b1 || req_ready_1 !== 1'b0) begin
            nerr++; $display("FAIL wr_grant: got ready %b%b, expected 10", req_ready_0, req_ready_1);
        end
        drive(1'b0, 1'b0, 5'd0, 16'h0, 1'b1, 1'b0, 5'd5, 16'h0);
        nvec += 2;
        if (req_ready_1 !== 1'b1) begin nerr++; $display("FAIL rd_grant: got ready1 %b, expected 1", req_ready_1); end
        if (rsp_data_0 !== 16'hB70D) begin nerr++; $display("FAIL wr_ack: got %h, expected b70d", rsp_data_0); end
        drive(1'b0, 1'b0, 5'd0, 16'h0, 1'b0, 1'b0, 5'd0, 16'h0);
        nvec++;
        if (rsp_valid_1 !== 1'b1 || rsp_data_1 !== 16'hB70D) begin
            nerr++; $display("FAIL rd_after_wr: got valid %b data %h, expected 1 b70d", rsp_valid_1, rsp_data_1);
        end
        drive(1'b0, 1'b0, 5'd0, 16'h0, 1'b0, 1'b0, 5'd0, 16'h0);
        nvec++;
        if (rsp_valid_0 !== 1'b0 || rsp_data_0 !== 16'hB70D) begin
            nerr++; $display("FAIL rsp_hold: got valid %b data %h, expected 0 b70d", rsp_valid_0, rsp_data_0);
        end
    endtask

    task automatic test_port1_then_tie();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 5'd0, 16'h0, 1'b1, 1'b0, 5'(20 + i), 16'h0);
            nvec++;
            if (req_ready_1 !== 1'b1 || req_ready_0 !== 1'b0) begin
                nerr++; $display("FAIL p1_only%0d: got ready %b%b, expected 01", i, req_ready_0, req_ready_1);
            end
        end
        drive(1'b1, 1'b1, 5'd21, 16'h5A5A, 1'b1, 1'b0, 5'd21, 16'h0);
        nvec++;
        if (req_ready_0 !== 1'b1 || req_ready_1 !== 1'b0) begin
            nerr++; $display("FAIL tie_p0_wins: got ready %b%b, expected 10", req_ready_0, req_ready_1);
        end
        drive(1'b0, 1'b0, 5'd0, 16'h0, 1'b1, 1'b0, 5'd21, 16'h0);
        nvec++;
        if (req_ready_1 !== 1'b1) begin nerr++; $display("FAIL pending_p1: got ready1 %b, expected 1", req_ready_1); end
        drive(1'b0, 1'b0, 5'd0, 16'h0, 1'b0, 1'b0, 5'd0, 16'h0);
    endtask

    task automatic test_back_to_back();
        int  i0, i1;
        logic prev0;
        i0 = 0; i1 = 0; prev0 = 1'b0;
        for (int c = 0; c < 8; c++) begin
            drive(i0 < 4, 1'b1, 5'(8 + i0), 16'(16'hA000 + i0),
                  i1 < 4, 1'b0, 5'(8 + i1), 16'h0);
            nvec += 2;
            if (req_ready_0 !== exp_g0 || req_ready_1 !== exp_g1) begin
                nerr++; $display("FAIL b2b_grant%0d: got ready %b%b, expected %b%b", c, req_ready_0, req_ready_1, exp_g0, exp_g1);
            end
            if (c > 0 && req_ready_0 !== !prev0) begin
                nerr++; $display("FAIL b2b_alternate%0d: got ready0 %b, expected %b", c, req_ready_0, !prev0);
            end
            prev0 = req_ready_0;
            if (exp_g0) i0++;
            if (exp_g1) i1++;
        end
        drive(1'b0, 1'b0, 5'd0, 16'h0, 1'b0, 1'b0, 5'd0, 16'h0);
        drive(1'b0, 1'b0, 5'd0, 16'h0, 1'b0, 1'b0, 5'd0, 16'h0);
    endtask

    task automatic test_drain();
        repeat (3) @(negedge clock);
        nvec++;
        if (q0.size() != 0 || q1.size() != 0) begin
            nerr++; $display("FAIL drain: got %0d/%0d outstanding responses, expected 0/0", q0.size(), q1.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model_mem[i] = 16'h1ec2 ^ 16'(i * 16'h1111);
        model_last = 1'b1;
        test_reset();
`ifndef RAM_ARB_SCRUB_EN
        test_init_read();
`else
        test_scrub();
`endif
        test_write_read();
        test_port1_then_tie();
        test_back_to_back();
        test_drain();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
